// File: rtl/fdce_shift_bank.sv
// WIDTH x DEPTH flop bank with clock enable, synchronous clear and valid tracking.
// Modes: shift delay line, hold, Johnson toggle, broadcast load.
module fdce_shift_bank #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4,
   parameter logic [WIDTH-1:0] INIT = '0,
   localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int FW = $clog2(DEPTH + 1)
) (
   input  logic             C,
   input  logic             CLR,
   input  logic             CE,
   input  logic [1:0]       MODE,
   input  logic [WIDTH-1:0] D,
   input  logic             DV,
   output logic [WIDTH-1:0] Q,
   output logic             QV,
   input  logic [SW-1:0]    TAP_SEL,
   output logic [WIDTH-1:0] TAP,
   output logic [FW-1:0]    FILL,
   output logic             FULL
);

   typedef enum logic [1:0] {
      M_SHIFT  = 2'b00,
      M_HOLD   = 2'b01,
      M_TOGGLE = 2'b10,
      M_LOAD   = 2'b11
   } mode_t;

   logic [WIDTH-1:0] s [DEPTH];
   logic [DEPTH-1:0] v;

   always_ff @(posedge C) begin
      if (CLR) begin
         for (int i = 0; i < DEPTH; i++) s[i] <= INIT;
         v <= '0;
      end else if (CE) begin
         unique case (mode_t'(MODE))
            M_SHIFT: begin
               s[0] <= D;
               v[0] <= DV;
               for (int i = 1; i < DEPTH; i++) begin
                  s[i] <= s[i-1];
                  v[i] <= v[i-1];
               end
            end
            // Inverted feedback from the last stage forms a Johnson ring.
            M_TOGGLE: begin
               s[0] <= ~s[DEPTH-1];
               v[0] <= 1'b1;
               for (int i = 1; i < DEPTH; i++) begin
                  s[i] <= s[i-1];
                  v[i] <= v[i-1];
               end
            end
            M_LOAD: begin
               for (int i = 0; i < DEPTH; i++) s[i] <= D;
               v <= {DEPTH{DV}};
            end
            default: ;
         endcase
      end
   end

   assign Q  = s[DEPTH-1];
   assign QV = v[DEPTH-1];

   always_comb begin
      FILL = '0;
      for (int i = 0; i < DEPTH; i++) FILL = FILL + FW'(v[i]);
   end

   assign FULL = (FILL == FW'(DEPTH));

   // Out-of-range selects fall through to zero.
   always_comb begin
      TAP = '0;
      for (int i = 0; i < DEPTH; i++)
         if (TAP_SEL == SW'(i)) TAP = s[i];
   end

endmodule

// File: tb/tb_fdce_shift_bank.sv
// Bench for fdce_shift_bank: four configurations share one stimulus stream,
// each compared against a packed-vector reference model.
module tb_fdce_shift_bank;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       ce = 1'b1;
   logic [1:0] mode = 2'b11;
   logic [7:0] d = 8'hFF;
   logic       dv = 1'b1;
   logic [1:0] tsel = 2'd0;
   logic       tsel1 = 1'b0;

   logic [7:0] q8, tap8;
   logic       qv8, full8;
   logic [2:0] fill8;
   logic [0:0] q1, tap1, fill1;
   logic       qv1, full1;
   logic [0:0] q4, tap4;
   logic       qv4, full4;
   logic [2:0] fill4;
   logic [7:0] q3, tap3;
   logic       qv3, full3;
   logic [1:0] fill3;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fdce_shift_bank #(.WIDTH(8), .DEPTH(4), .INIT(8'hA5)) u8 (
      .C(clk), .CLR(clr), .CE(ce), .MODE(mode), .D(d), .DV(dv),
      .Q(q8), .QV(qv8), .TAP_SEL(tsel), .TAP(tap8),
      .FILL(fill8), .FULL(full8));

   fdce_shift_bank #(.WIDTH(1), .DEPTH(1), .INIT(1'b0)) u1 (
      .C(clk), .CLR(clr), .CE(ce), .MODE(mode), .D(d[0:0]), .DV(dv),
      .Q(q1), .QV(qv1), .TAP_SEL(tsel1), .TAP(tap1),
      .FILL(fill1), .FULL(full1));

   fdce_shift_bank #(.WIDTH(1), .DEPTH(4), .INIT(1'b0)) u4 (
      .C(clk), .CLR(clr), .CE(ce), .MODE(mode), .D(d[0:0]), .DV(dv),
      .Q(q4), .QV(qv4), .TAP_SEL(tsel), .TAP(tap4),
      .FILL(fill4), .FULL(full4));

   fdce_shift_bank #(.WIDTH(8), .DEPTH(3), .INIT(8'h5A)) u3 (
      .C(clk), .CLR(clr), .CE(ce), .MODE(mode), .D(d), .DV(dv),
      .Q(q3), .QV(qv3), .TAP_SEL(tsel), .TAP(tap3),
      .FILL(fill3), .FULL(full3));

   // Model: stage i of instance k lives in ms[k][8*i +: 8].
   int         dep [4] = '{4, 1, 4, 3};
   logic [7:0] wm  [4] = '{8'hFF, 8'h01, 8'h01, 8'hFF};
   logic [7:0] ini [4] = '{8'hA5, 8'h00, 8'h00, 8'h5A};
   logic [63:0] ms [4];
   logic [3:0]  mv [4];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] rep(input logic [7:0] x, input int n);
      logic [63:0] r = '0;
      for (int i = 0; i < n; i++) r = r | (64'(x) << (8 * i));
      return r;
   endfunction

   function automatic logic [7:0] stg(input int k, input int i);
      return 8'(ms[k] >> (8 * i)) & wm[k];
   endfunction

   task automatic model(input logic c, input logic e, input logic [1:0] m,
                        input logic [7:0] dd, input logic ddv);
      for (int k = 0; k < 4; k++) begin
         logic [63:0] am;
         logic [3:0]  vm;
         logic [7:0]  dk, last;
         am = (64'h1 << (8 * dep[k])) - 64'h1;
         vm = 4'((5'h1 << dep[k]) - 5'h1);
         dk = dd & wm[k];
         last = stg(k, dep[k] - 1);
         if (c) begin
            ms[k] = rep(ini[k], dep[k]);
            mv[k] = '0;
         end else if (e) begin
            case (m)
               2'b00: begin
                  ms[k] = ((ms[k] << 8) | 64'(dk)) & am;
                  mv[k] = ((mv[k] << 1) | 4'(ddv)) & vm;
               end
               2'b10: begin
                  ms[k] = ((ms[k] << 8) | 64'(~last & wm[k])) & am;
                  mv[k] = ((mv[k] << 1) | 4'h1) & vm;
               end
               2'b11: begin
                  ms[k] = rep(dk, dep[k]);
                  mv[k] = ddv ? vm : 4'h0;
               end
               default: ;
            endcase
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 4; k++) begin
         logic [7:0] aq;
         logic [3:0] af;
         logic       aqv, afl;
         int         ef;
         case (k)
            0: begin aq = q8; aqv = qv8; af = 4'(fill8); afl = full8; end
            1: begin aq = 8'(q1); aqv = qv1; af = 4'(fill1); afl = full1; end
            2: begin aq = 8'(q4); aqv = qv4; af = 4'(fill4); afl = full4; end
            default: begin aq = q3; aqv = qv3; af = 4'(fill3); afl = full3; end
         endcase
         ef = $countones(mv[k]);
         check($sformatf("q%0d", k), 32'(aq), 32'(stg(k, dep[k] - 1)));
         check($sformatf("qv%0d", k), 32'(aqv), 32'(mv[k][dep[k] - 1]));
         check($sformatf("fill%0d", k), 32'(af), 32'(ef));
         check($sformatf("full%0d", k), 32'(afl), 32'(ef == dep[k]));
      end
      for (int s = 0; s < 4; s++) begin
         logic [1:0] sv;
         sv = 2'(s);
         tsel = sv;
         tsel1 = sv[0];
         #1;
         check($sformatf("tap8_%0d", s), 32'(tap8),
               32'((s < dep[0]) ? stg(0, s) : 8'h00));
         check($sformatf("tap4_%0d", s), 32'(tap4),
               32'((s < dep[2]) ? stg(2, s) : 8'h00));
         check($sformatf("tap3_%0d", s), 32'(tap3),
               32'((s < dep[3]) ? stg(3, s) : 8'h00));
         if (s < 2)
            check($sformatf("tap1_%0d", s), 32'(tap1),
                  32'((s < dep[1]) ? stg(1, s) : 8'h00));
      end
   endtask

   task automatic step(input logic c, input logic e, input logic [1:0] m,
                       input logic [7:0] dd, input logic ddv);
      clr = c;
      ce = e;
      mode = m;
      d = dd;
      dv = ddv;
      @(posedge clk);
      model(c, e, m, dd, ddv);
      #1;
      check_all();
   endtask

   logic [3:0] jt [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                          4'b1110, 4'b1100, 4'b1000, 4'b0000};
   int         fexp [5] = '{1, 2, 3, 4, 4};

   initial begin
      for (int k = 0; k < 4; k++) begin
         ms[k] = '0;
         mv[k] = '0;
      end

      // Reset with a load request that must lose.
      step(1'b1, 1'b1, 2'b11, 8'hFF, 1'b1);
      step(1'b1, 1'b1, 2'b11, 8'hFF, 1'b1);
      check("rst_q", 32'(q8), 32'hA5);
      check("rst_fill", 32'(fill8), 32'd0);

      // Shift fill.
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 2'b00, 8'(i + 1), 1'b1);
         check("sf_fill", 32'(fill8), 32'(fexp[i]));
         if (i == 3) check("sf_q4", 32'(q8), 32'h01);
         if (i == 4) check("sf_q5", 32'(q8), 32'h02);
      end

      // Shift with one CE gap and an invalid word.
      step(1'b1, 1'b1, 2'b00, 8'h00, 1'b0);
      step(1'b0, 1'b1, 2'b00, 8'h01, 1'b1);
      step(1'b0, 1'b1, 2'b00, 8'h02, 1'b0);
      step(1'b0, 1'b0, 2'b00, 8'h99, 1'b1);
      check("gap_q", 32'(q8), 32'hA5);
      check("gap_fill", 32'(fill8), 32'd1);
      step(1'b0, 1'b1, 2'b00, 8'h03, 1'b1);
      step(1'b0, 1'b1, 2'b00, 8'h04, 1'b1);
      check("gap_q1", 32'(q8), 32'h01);
      check("gap_fill3", 32'(fill8), 32'd3);
      step(1'b0, 1'b1, 2'b00, 8'h05, 1'b1);
      check("gap_q2", 32'(q8), 32'h02);
      check("gap_qv2", 32'(qv8), 32'd0);

      // Toggle: divider and Johnson ring.
      step(1'b1, 1'b1, 2'b00, 8'h00, 1'b0);
      for (int j = 0; j < 16; j++) begin
         step(1'b0, 1'b1, 2'b10, 8'($urandom), 1'($urandom));
         check("tog_div", 32'(q1), 32'((j % 2 == 0) ? 1 : 0));
         check("tog_jc", 32'(q4), 32'(jt[j % 8][3]));
      end

      // Load, then clear colliding with load.
      step(1'b0, 1'b1, 2'b11, 8'h3C, 1'b1);
      check("ld_fill", 32'(fill8), 32'd4);
      check("ld_q", 32'(q8), 32'h3C);
      step(1'b1, 1'b1, 2'b11, 8'h77, 1'b1);
      check("ldclr_fill", 32'(fill8), 32'd0);
      check("ldclr_q", 32'(q8), 32'hA5);
      check("ldclr_q3", 32'(q3), 32'h5A);

      // Randomized traffic.
      for (int n = 0; n < 400; n++)
         step(1'(($urandom % 16) == 0), 1'(($urandom % 4) != 0),
              2'($urandom), 8'($urandom), 1'($urandom));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
